// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory request/response, held instruction to decode,
// and retire/redirect controls from the execute stage.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic [31:0]       instr;
  logic              instr_valid;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              instr_ready;
  logic              stall;
  logic              pc_src;
  logic              jump;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, opcode, funct, pc, pc_plus4,
    input  imem_rvalid, imem_rdata, instr_ready, stall, pc_src, jump
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, opcode, funct, pc, pc_plus4,
    output imem_rvalid, imem_rdata, instr_ready, stall, pc_src, jump
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC owner and FETCH/WAIT/HOLD fetch sequencer: 3 cycles per instruction with a 1-cycle memory;
// waits indefinitely for imem_rvalid and holds the instruction until retired with stall low.
module instr_fetch_unit #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
);
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] branch_off;
  logic [ADDR_W-1:0] next_pc;
  logic [31:0]       instr_q;
  logic              retire;

  assign pc_plus4   = pc + ADDR_W'(4);
  assign branch_off = {{(ADDR_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};
  assign retire     = (state == HOLD) && bus.instr_ready && !bus.stall;

  // Jump outranks a taken branch when the control stage raises both.
  always_comb begin
    next_pc = pc_plus4;
    if (bus.jump) begin
      next_pc = {pc_plus4[ADDR_W-1:28], instr_q[25:0], 2'b00};
    end else if (bus.pc_src) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      instr_q <= '0;
    end else begin
      case (state)
        FETCH: state <= WAIT;
        WAIT: begin
          if (bus.imem_rvalid) begin
            instr_q <= bus.imem_rdata;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (retire) begin
            pc    <= next_pc;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // The request is masked while reset is asserted even though the state already reads FETCH.
  assign bus.imem_req    = (state == FETCH) && rst_n;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = (state == HOLD);
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[31:26];
  assign bus.funct       = instr_q[5:0];
  assign bus.pc          = pc;
  assign bus.pc_plus4    = pc_plus4;
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage for the single-cycle MIPS datapath.
- Owns the PC register and fetches instructions from instruction memory over a request/valid handshake.
- Holds each fetched instruction stable for the decode/control stage, which reads opcode [31:26] and funct [5:0].
- Computes the next PC from the control stage's pc_src/jump decisions once the instruction is retired.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width; instruction width fixed at 32.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  one-cycle fetch request strobe.
- imem_addr  output  ADDR_W  fetch address, equal to the current PC.
- imem_rvalid  input  1  read data valid from instruction memory.
- imem_rdata  input  32  instruction word.
- instr  output  32  held instruction.
- instr_valid  output  1  instr is valid for decode/execute.
- opcode  output  6  instr[31:26].
- funct  output  6  instr[5:0].
- pc  output  ADDR_W  address of the held instruction.
- pc_plus4  output  ADDR_W  pc+4, modulo 2^ADDR_W.
- instr_ready  input  1  execute stage retires the held instruction this cycle.
- stall  input  1  freeze: blocks retirement while high.
- pc_src  input  1  branch taken (Branch & Zero) from the control stage.
- jump  input  1  jump from the control stage.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0.
  - opcode=0, funct=0, pc_plus4=RESET_PC+4.
- Outputs imem_req and instr_valid are combinational from state. imem_addr=pc at all times.
- FSM state FETCH:
  - imem_req=1 for exactly this cycle.
  - Next state: WAIT.
- FSM state WAIT:
  - imem_req=0.
  - On imem_rvalid=1: register instr<=imem_rdata, go to HOLD.
  - Otherwise remain in WAIT; there is no timeout.
- FSM state HOLD:
  - instr_valid=1; instr, pc and pc_plus4 are stable.
  - When instr_ready=1 and stall=0: update pc (see next-PC rules), go to FETCH.
  - Otherwise remain in HOLD.
- imem_rvalid outside WAIT is ignored; instr is unchanged.
- Next-PC selection, evaluated with the pc_src/jump values of the retiring cycle, priority jump > pc_src > sequential:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - pc_src=1: pc_plus4 + (sign_extend(instr[15:0]) << 2), truncated to ADDR_W.
  - Otherwise: pc_plus4.
- Arithmetic: all adds wrap modulo 2^ADDR_W (0xFFFF_FFFC+4 = 0x0000_0000). pc[1:0] is always 00.
- pc_src/jump are don't-care outside a retiring HOLD cycle.
- Minimum throughput: 3 cycles per instruction (FETCH, WAIT, HOLD) with a 1-cycle memory.
- Reset mid-WAIT or mid-HOLD returns to FETCH at RESET_PC. Instruction memory shares rst_n and drops any outstanding read.
- instr_valid deasserts in the cycle after retirement (state FETCH).

Test Plan:
- Reset, then release rst_n with 1-cycle memory returning 0x0000_0020 -> imem_req=1 with imem_addr=0x0 in the first cycle, instr_valid=1 two cycles later, opcode=0, funct=0x20.
- Sequential run of 3 instructions, instr_ready held 1 -> fetch addresses 0x0, 0x4, 0x8, each retiring 3 cycles apart.
- Instruction 0x1000_FFFF at pc=0x10, pc_src=1 on retire -> next imem_addr=0x10 (0x14 + (-4)); with pc_src=0 -> 0x14.
- Instruction 0x0800_0040 at pc=0x4000_0000, jump=1 and pc_src=1 together -> next imem_addr=0x4000_0100 (jump wins).
- stall=1 for 5 cycles during HOLD with instr_ready=1 -> instr, pc and instr_valid unchanged and no imem_req; retires on the first cycle with stall=0.
- Wrap and async reset:
  - pc=0xFFFF_FFFC retiring sequentially -> next imem_addr=0x0.
  - rst_n pulsed low mid-WAIT -> outputs go to reset values immediately.
  - A late imem_rvalid after reset while in FETCH is ignored.
